evt_counter_bank: RTL and testbench

- Parametrised successor to the single-channel event counter: a bank of NUM_CH independent event counters with a shared runtime-programmable period.
- Adds per-channel clear, wrap pulses, sticky wrap flags and an atomic snapshot of all channels.
- Used by the sonar datapath to count echo/pulse events per receiver channel, with frame-aligned readout.

---
 rtl/evt_counter_bank.sv | 94 +++++++++
 tb/tb_evt_counter_bank.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_counter_bank.sv
// evt_counter_bank: NUM_CH independent event counters sharing a runtime
// period, with per-channel clear, wrap pulse, sticky wrap flag and an
// atomic snapshot of all channel counts.
// Build option: define EVT_COUNTER_BANK_SATURATE_EN to make channels
// saturate at term instead of wrapping (wrap_flag_out becomes a sticky
// saturation flag).
module evt_counter_bank #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    en_in,
  input  logic [NUM_CH-1:0]       evt_in,
  input  logic [NUM_CH-1:0]       clr_in,
  input  logic [WIDTH-1:0]        period_in,
  input  logic                    snap_in,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       wrap_out,
  output logic [NUM_CH-1:0]       wrap_flag_out,
  output logic [NUM_CH*WIDTH-1:0] snap_out,
  output logic                    snap_valid_out
);

  logic [WIDTH-1:0] term;
  logic             snap_valid_q;

  // Modular subtraction: period 0 yields the all-ones terminal count.
  assign term = period_in - WIDTH'(1);

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] snap_q;
    logic             wrap_q;
    logic             flag_q;

    // Per-channel counter: clear beats event; event at/after term wraps
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        cnt_q  <= '0;
        wrap_q <= 1'b0;
        flag_q <= 1'b0;
      end else if (clr_in[g]) begin
        cnt_q  <= '0;
        wrap_q <= 1'b0;
        flag_q <= 1'b0;
      end else if (en_in && evt_in[g]) begin
        if (cnt_q >= term) begin
`ifdef EVT_COUNTER_BANK_SATURATE_EN
          // Pulse only on the first overflow attempt; the flag then masks it.
          cnt_q  <= term;
          wrap_q <= ~flag_q;
          flag_q <= 1'b1;
`else
          cnt_q  <= '0;
          wrap_q <= 1'b1;
          flag_q <= 1'b1;
`endif
        end else begin
          cnt_q  <= cnt_q + WIDTH'(1);
          wrap_q <= 1'b0;
        end
      end else begin
        wrap_q <= 1'b0;
      end
    end

    // Snapshot captures the count held before this edge (pre-event, pre-clear)
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        snap_q <= '0;
      end else if (snap_in) begin
        snap_q <= cnt_q;
      end
    end

    assign count_out[g*WIDTH +: WIDTH] = cnt_q;
    assign snap_out[g*WIDTH +: WIDTH]  = snap_q;
    assign wrap_out[g]                 = wrap_q;
    assign wrap_flag_out[g]            = flag_q;
  end

  // One-cycle valid pulse following every snapshot request
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= snap_in;
    end
  end

  assign snap_valid_out = snap_valid_q;

endmodule

// File: tb/tb_evt_counter_bank.sv
// tb_evt_counter_bank: table-driven vectors, directed corner sequences and a
// randomized run against a behavioural model for evt_counter_bank.
module tb_evt_counter_bank;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        en_in;
  logic [3:0]  evt_in, clr_in;
  logic [15:0] period_in;
  logic        snap_in;
  logic [63:0] count_out, snap_out;
  logic [3:0]  wrap_out, wrap_flag_out;
  logic        snap_valid_out;

  logic        en4, evt4, clr4, snap4, wrap4, flag4, sv4;
  logic [3:0]  per4, cnt4, snp4;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  evt_counter_bank #(.NUM_CH(4), .WIDTH(16)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .evt_in(evt_in),
    .clr_in(clr_in), .period_in(period_in), .snap_in(snap_in),
    .count_out(count_out), .wrap_out(wrap_out), .wrap_flag_out(wrap_flag_out),
    .snap_out(snap_out), .snap_valid_out(snap_valid_out)
  );

  evt_counter_bank #(.NUM_CH(1), .WIDTH(4)) u_dut4 (
    .clk_in(clk_in), .rst_in(rst_in), .en_in(en4), .evt_in(evt4),
    .clr_in(clr4), .period_in(per4), .snap_in(snap4),
    .count_out(cnt4), .wrap_out(wrap4), .wrap_flag_out(flag4),
    .snap_out(snp4), .snap_valid_out(sv4)
  );

  typedef struct {
    logic        en;
    logic [3:0]  evt;
    logic [3:0]  clr;
    logic        snap;
    logic [15:0] per;
    logic [63:0] cnt;
    logic [3:0]  wrap;
    logic [3:0]  flag;
    logic        sv;
    logic [63:0] snp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [15:0] ch(input int i);
    return count_out[i*16 +: 16];
  endfunction

  function automatic vec_t mk(input logic e, input logic [3:0] ev, input logic [3:0] cl,
                              input logic sn, input logic [15:0] p, input logic [63:0] c,
                              input logic [3:0] w, input logic [3:0] f, input logic v,
                              input logic [63:0] s);
    vec_t r;
    r.en = e; r.evt = ev; r.clr = cl; r.snap = sn; r.per = p;
    r.cnt = c; r.wrap = w; r.flag = f; r.sv = v; r.snp = s;
    return r;
  endfunction

  task automatic drive(input logic e, input logic [3:0] ev, input logic [3:0] cl,
                       input logic sn, input logic [15:0] p);
    en_in = e; evt_in = ev; clr_in = cl; snap_in = sn; period_in = p;
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    drive(1'b0, 4'b0, 4'b0, 1'b0, 16'd0);
    en4 = 1'b0; evt4 = 1'b0; clr4 = 1'b0; snap4 = 1'b0; per4 = 4'd0;
    cyc();
    rst_in = 1'b0;
  endtask

  // Behavioural reference state for the randomized run
  longint unsigned m_cnt[4], m_snp[4];
  bit              m_wrap[4], m_flag[4], m_sv;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef EVT_COUNTER_BANK_SATURATE_EN
    tbl[0] = mk(1, 4'b0001, 4'b0000, 0, 16'd3, pk(1,0,0,0), 4'b0000, 4'b0000, 0, '0);
    tbl[1] = mk(1, 4'b0011, 4'b0000, 0, 16'd3, pk(2,1,0,0), 4'b0000, 4'b0000, 0, '0);
    tbl[2] = mk(1, 4'b0111, 4'b0000, 0, 16'd3, pk(2,2,1,0), 4'b0001, 4'b0001, 0, '0);
    tbl[3] = mk(1, 4'b1111, 4'b0000, 1, 16'd3, pk(2,2,2,1), 4'b0010, 4'b0011, 1, pk(2,2,1,0));
    tbl[4] = mk(0, 4'b1111, 4'b0100, 0, 16'd3, pk(2,2,0,1), 4'b0000, 4'b0011, 0, '0);
    tbl[5] = mk(1, 4'b1000, 4'b0000, 0, 16'd1, pk(2,2,0,0), 4'b1000, 4'b1011, 0, '0);
`else
    tbl[0] = mk(1, 4'b0001, 4'b0000, 0, 16'd3, pk(1,0,0,0), 4'b0000, 4'b0000, 0, '0);
    tbl[1] = mk(1, 4'b0011, 4'b0000, 0, 16'd3, pk(2,1,0,0), 4'b0000, 4'b0000, 0, '0);
    tbl[2] = mk(1, 4'b0111, 4'b0000, 0, 16'd3, pk(0,2,1,0), 4'b0001, 4'b0001, 0, '0);
    tbl[3] = mk(1, 4'b1111, 4'b0000, 1, 16'd3, pk(1,0,2,1), 4'b0010, 4'b0011, 1, pk(0,2,1,0));
    tbl[4] = mk(0, 4'b1111, 4'b0100, 0, 16'd3, pk(1,0,0,1), 4'b0000, 4'b0011, 0, '0);
    tbl[5] = mk(1, 4'b1000, 4'b0000, 0, 16'd1, pk(1,0,0,0), 4'b1000, 4'b1011, 0, '0);
`endif

    // Reset values
    do_reset();
    rst_in = 1'b1;
    #2;
    chk("rst_count", count_out, '0);
    chk("rst_wrap", wrap_out, '0);
    chk("rst_flag", wrap_flag_out, '0);
    chk("rst_snap", snap_out, '0);
    chk("rst_sv", snap_valid_out, '0);
    rst_in = 1'b0;

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].en, tbl[i].evt, tbl[i].clr, tbl[i].snap, tbl[i].per);
      cyc();
      chk($sformatf("tbl%0d_cnt", i), count_out, tbl[i].cnt);
      chk($sformatf("tbl%0d_wrap", i), wrap_out, tbl[i].wrap);
      chk($sformatf("tbl%0d_flag", i), wrap_flag_out, tbl[i].flag);
      chk($sformatf("tbl%0d_sv", i), snap_valid_out, tbl[i].sv);
      if (tbl[i].sv) chk($sformatf("tbl%0d_snap", i), snap_out, tbl[i].snp);
    end

    // Asynchronous reset mid-count, snapshot pulse killed by reset
    do_reset();
    drive(1, 4'b0001, 4'b0, 0, 16'd0);
    for (int i = 0; i < 7; i++) cyc();
    chk("ar_pre", ch(0), 16'd7);
    drive(1, 4'b0000, 4'b0, 1, 16'd0);
    cyc();
    chk("ar_sv_pre", snap_valid_out, 1'b1);
    drive(1, 4'b0000, 4'b0, 0, 16'd0);
    #2 rst_in = 1'b1;
    #1;
    chk("ar_count", count_out, '0);
    chk("ar_flag", wrap_flag_out, '0);
    chk("ar_sv", snap_valid_out, 1'b0);
    chk("ar_snap", snap_out, '0);
    cyc();
    rst_in = 1'b0;
    cyc();
    chk("ar_sv_rel", snap_valid_out, 1'b0);
    drive(1, 4'b0001, 4'b0, 0, 16'd0);
    for (int i = 0; i < 5; i++) cyc();
    chk("basic5", count_out, pk(5,0,0,0));

    // Wrap on ch2 with period 10
    do_reset();
    drive(1, 4'b0100, 4'b0, 0, 16'd10);
    for (int i = 0; i < 9; i++) cyc();
    chk("w_9", ch(2), 16'd9);
    chk("w_9_wrap", wrap_out, 4'b0000);
    cyc();
`ifdef EVT_COUNTER_BANK_SATURATE_EN
    chk("w_10", ch(2), 16'd9);
`else
    chk("w_10", ch(2), 16'd0);
`endif
    chk("w_10_wrap", wrap_out, 4'b0100);
    chk("w_10_flag", wrap_flag_out, 4'b0100);
    drive(1, 4'b0000, 4'b0, 0, 16'd10);
    cyc();
    chk("w_pulse_end", wrap_out, 4'b0000);
    drive(1, 4'b0100, 4'b0, 0, 16'd10);
    for (int i = 0; i < 3; i++) cyc();
`ifdef EVT_COUNTER_BANK_SATURATE_EN
    chk("w_13", ch(2), 16'd9);
`else
    chk("w_13", ch(2), 16'd3);
`endif
    chk("w_13_flag", wrap_flag_out, 4'b0100);
    chk("w_13_wrap", wrap_out, 4'b0000);

    // Clear beats event; en low blocks events
    do_reset();
    drive(1, 4'b0011, 4'b0, 0, 16'd0);
    for (int i = 0; i < 4; i++) cyc();
    drive(1, 4'b0011, 4'b0010, 0, 16'd0);
    cyc();
    chk("clr_cnt", count_out, pk(5,0,0,0));
    chk("clr_flag", wrap_flag_out, 4'b0000);
    drive(0, 4'b1111, 4'b0, 0, 16'd0);
    for (int i = 0; i < 4; i++) cyc();
    chk("en_off", count_out, pk(5,0,0,0));

    // Snapshot atomicity, clear on the snapshot edge
    do_reset();
    drive(1, 4'b1111, 4'b0, 0, 16'd0); cyc();
    drive(1, 4'b1110, 4'b0, 0, 16'd0); cyc();
    drive(1, 4'b1100, 4'b0, 0, 16'd0); cyc();
    drive(1, 4'b1000, 4'b0, 0, 16'd0); cyc();
    drive(1, 4'b1111, 4'b0, 1, 16'd0); cyc();
    chk("snap_val", snap_out, pk(1,2,3,4));
    chk("snap_cnt", count_out, pk(2,3,4,5));
    chk("snap_sv1", snap_valid_out, 1'b1);
    drive(1, 4'b0000, 4'b0001, 1, 16'd0); cyc();
    chk("snap_clr", snap_out, pk(2,3,4,5));
    chk("snap_clr_cnt", count_out, pk(0,3,4,5));
    chk("snap_b2b", snap_valid_out, 1'b1);
    drive(1, 4'b0000, 4'b0, 0, 16'd0); cyc();
    chk("snap_sv0", snap_valid_out, 1'b0);

    // Period lowered below count on ch3
    do_reset();
    drive(1, 4'b1000, 4'b0, 0, 16'd0);
    for (int i = 0; i < 8; i++) cyc();
    chk("pl_8", ch(3), 16'd8);
    drive(1, 4'b1000, 4'b0, 0, 16'd5);
    cyc();
`ifdef EVT_COUNTER_BANK_SATURATE_EN
    chk("pl_cnt", ch(3), 16'd4);
    chk("pl_wrap", wrap_out, 4'b1000);
    cyc();
    chk("pl_cnt2", ch(3), 16'd4);
    chk("pl_wrap2", wrap_out, 4'b0000);
`else
    chk("pl_cnt", ch(3), 16'd0);
    chk("pl_wrap", wrap_out, 4'b1000);
    cyc();
    chk("pl_cnt2", ch(3), 16'd1);
    chk("pl_wrap2", wrap_out, 4'b0000);
`endif

    // Full-width boundary on a 4-bit channel, period 0
    do_reset();
    en4 = 1'b1; evt4 = 1'b1; per4 = 4'd0;
    for (int i = 0; i < 15; i++) cyc();
    chk("fw_15", cnt4, 4'd15);
    chk("fw_15_wrap", wrap4, 1'b0);
    cyc();
`ifdef EVT_COUNTER_BANK_SATURATE_EN
    chk("fw_16", cnt4, 4'd15);
`else
    chk("fw_16", cnt4, 4'd0);
`endif
    chk("fw_16_wrap", wrap4, 1'b1);
    chk("fw_16_flag", flag4, 1'b1);
    evt4 = 1'b0;
    cyc();
    chk("fw_pulse_end", wrap4, 1'b0);

    // Randomized run against the behavioural model
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_snp[i] = 0; m_wrap[i] = 0; m_flag[i] = 0;
    end
    m_sv = 0;
    period_in = 16'd4;
    for (int n = 0; n < 600; n++) begin
      logic [3:0]      r_clr;
      longint unsigned term;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: period_in = 16'd0;
          1: period_in = 16'd1;
          2: period_in = 16'd2;
          3: period_in = 16'($urandom_range(3, 12));
          4: period_in = 16'($urandom);
          default: period_in = 16'd5;
        endcase
      end
      for (int b = 0; b < 4; b++) r_clr[b] = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 7) != 0, 4'($urandom), r_clr,
            $urandom_range(0, 3) == 0, period_in);

      term = (period_in == 16'd0) ? 64'd65535 : longint'(period_in) - 1;
      m_sv = snap_in;
      for (int i = 0; i < 4; i++) begin
        if (snap_in) m_snp[i] = m_cnt[i];
        if (clr_in[i]) begin
          m_cnt[i] = 0; m_flag[i] = 0; m_wrap[i] = 0;
        end else if (en_in && evt_in[i]) begin
          if (m_cnt[i] >= term) begin
`ifdef EVT_COUNTER_BANK_SATURATE_EN
            m_wrap[i] = !m_flag[i];
            m_cnt[i]  = term;
`else
            m_wrap[i] = 1;
            m_cnt[i]  = 0;
`endif
            m_flag[i] = 1;
          end else begin
            m_cnt[i]  = m_cnt[i] + 1;
            m_wrap[i] = 0;
          end
        end else begin
          m_wrap[i] = 0;
        end
      end
      cyc();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rnd%0d_cnt%0d", n, i), ch(i), m_cnt[i]);
        chk($sformatf("rnd%0d_wrap%0d", n, i), wrap_out[i], m_wrap[i]);
        chk($sformatf("rnd%0d_flag%0d", n, i), wrap_flag_out[i], m_flag[i]);
        chk($sformatf("rnd%0d_snap%0d", n, i), snap_out[i*16 +: 16], m_snp[i]);
      end
      chk($sformatf("rnd%0d_sv", n), snap_valid_out, m_sv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
